// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, multi-cycle memory between the
// fetch stage and the memory stage of the 16-bit pipeline. Data accesses win
// over fetches, flushed fetches are completed but discarded, and an access
// that never completes raises a sticky err and is abandoned.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        flush,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic [15:0] if_instr,
  output logic        if_valid,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        if_stall,
  output logic        d_stall,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;

  // Counter value seen during the TIMEOUT-th outstanding cycle.
  localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT - 1);

  logic [1:0] stateReg;
  logic [7:0] cycleCnt;
  logic       discardReg;
  logic       timeoutHit;

  assign timeoutHit = (cycleCnt == LAST_CYCLE);

  // Any non-idle state means an access is outstanding at the memory.
  assign mem_req = (stateReg != IDLE);

  // Stalls follow the raw requests and drop only in the valid-pulse cycle.
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = (d_rd | d_wr) & ~d_valid;

  // Grant, track and retire memory accesses; valid pulses last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      cycleCnt   <= '0;
      discardReg <= 1'b0;
      err        <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_instr   <= '0;
      if_valid   <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (stateReg)
        IDLE: begin
          // mem_done arriving here belongs to nothing and is ignored.
          cycleCnt   <= '0;
          discardReg <= 1'b0;
          if (d_rd | d_wr) begin
            // Data is the older instruction, so it always goes first.
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wr    <= d_wr;
            stateReg  <= DATA;
          end else if (if_req & ~flush) begin
            mem_addr <= if_addr;
            mem_wr   <= 1'b0;
            stateReg <= FETCH;
          end
        end
        FETCH: begin
          if (mem_done) begin
            // A flush at any point of the access, including now, kills the pulse.
            if_instr   <= mem_rdata;
            if_valid   <= ~(discardReg | flush);
            stateReg   <= IDLE;
            discardReg <= 1'b0;
            cycleCnt   <= '0;
          end else if (timeoutHit) begin
            err        <= 1'b1;
            stateReg   <= IDLE;
            discardReg <= 1'b0;
            cycleCnt   <= '0;
          end else begin
            cycleCnt <= cycleCnt + 8'd1;
            if (flush) begin
              discardReg <= 1'b1;
            end
          end
        end
        DATA: begin
          if (mem_done) begin
            // Writes are acknowledged without disturbing the last load value.
            if (!mem_wr) begin
              d_rdata <= mem_rdata;
            end
            d_valid  <= 1'b1;
            mem_wr   <= 1'b0;
            stateReg <= IDLE;
            cycleCnt <= '0;
          end else if (timeoutHit) begin
            err      <= 1'b1;
            mem_wr   <= 1'b0;
            stateReg <= IDLE;
            cycleCnt <= '0;
          end else begin
            cycleCnt <= cycleCnt + 8'd1;
          end
        end
        default: begin
          stateReg <= IDLE;
          mem_wr   <= 1'b0;
          cycleCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a responding memory model, a scoreboard of
// expected accesses and valid pulses, and a driver mixing directed and random
// fetch/load/store traffic with flush, timeout and reset cases.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        flush = 1'b0;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic [15:0] if_instr;
  logic        if_valid;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        if_stall;
  logic        d_stall;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .if_instr(if_instr), .if_valid(if_valid),
    .d_rdata(d_rdata), .d_valid(d_valid), .if_stall(if_stall), .d_stall(d_stall), .err(err)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
  } acc_t;

  acc_t        accQ[$];
  logic [15:0] ifQ[$];
  logic [15:0] dQ[$];
  logic [15:0] memArr [logic [15:0]];
  logic [15:0] refMem [logic [15:0]];
  logic [15:0] lastRd = '0;
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          doneCyc = -10;
  bit          hang = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] initVal(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] refRead(input logic [15:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  function automatic logic [15:0] memRead(input logic [15:0] a);
    return memArr.exists(a) ? memArr[a] : initVal(a);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Memory device: accepts each access, checks it against the expected order,
  // answers after a random delay (or never while hang is set).
  initial begin : responder
    bit   busy;
    int   remaining;
    acc_t cur;
    busy = 1'b0;
    remaining = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (mem_done) begin
        mem_done = 1'b0;
        busy = 1'b0;
      end else if (busy && !mem_req) begin
        busy = 1'b0;
      end else if (busy) begin
        check("mem_addr_hold", mem_addr, cur.addr);
        check("mem_wr_hold", mem_wr, cur.wr);
        remaining--;
        if (remaining == 0) begin
          if (cur.wr) begin
            memArr[cur.addr] = cur.wdata;
            mem_rdata = 16'hDEAD;
          end else begin
            mem_rdata = memRead(cur.addr);
          end
          mem_done = 1'b1;
          doneCyc = cyc;
        end
      end else if (mem_req) begin
        busy = 1'b1;
        if (accQ.size() == 0) begin
          check("unexpected_access", 1, 0);
          cur = '{addr: mem_addr, wr: mem_wr, wdata: mem_wdata};
        end else begin
          cur = accQ.pop_front();
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wr", mem_wr, cur.wr);
          if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
        end
        remaining = hang ? 1000000 : int'($urandom_range(1, 4));
      end
    end
  end

  // Monitor: stall equations, exclusive valids, and scoreboard pops.
  initial begin : monitor
    forever begin
      @(negedge clk);
      check("if_stall", if_stall, if_req & ~if_valid);
      check("d_stall", d_stall, (d_rd | d_wr) & ~d_valid);
      check("valid_exclusive", if_valid & d_valid, 0);
      if (if_valid) begin
        if (ifQ.size() == 0) check("if_valid_unexpected", 1, 0);
        else begin
          check("if_instr", if_instr, ifQ.pop_front());
          $display("fetch  instr=%h cycle=%0d", if_instr, cyc);
        end
        check("if_latency", cyc - doneCyc, 1);
      end
      if (d_valid) begin
        if (dQ.size() == 0) check("d_valid_unexpected", 1, 0);
        else begin
          check("d_rdata", d_rdata, dQ.pop_front());
          $display("data   rdata=%h cycle=%0d", d_rdata, cyc);
        end
        check("d_latency", cyc - doneCyc, 1);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input bit isData, input string name);
    int n;
    for (n = 0; n < 60; n++) begin
      tick();
      if (isData ? d_valid : if_valid) break;
    end
    if (n == 60) check({name, "_no_valid"}, 0, 1);
  endtask

  task automatic waitMemReq(input string name);
    int n;
    for (n = 0; n < 20; n++) begin
      tick();
      if (mem_req) break;
    end
    if (n == 20) check({name, "_no_mem_req"}, 0, 1);
  endtask

  task automatic doFetch(input logic [15:0] a);
    if_req = 1'b1;
    if_addr = a;
    accQ.push_back('{addr: a, wr: 1'b0, wdata: 16'h0});
    ifQ.push_back(refRead(a));
    waitValid(1'b0, "fetch");
    if_req = 1'b0;
  endtask

  task automatic pushData(input bit wr, input logic [15:0] a, input logic [15:0] wd);
    accQ.push_back('{addr: a, wr: wr, wdata: wd});
    if (wr) refMem[a] = wd;
    else lastRd = refRead(a);
    dQ.push_back(lastRd);
  endtask

  task automatic doData(input bit wr, input logic [15:0] a, input logic [15:0] wd);
    d_rd = ~wr;
    d_wr = wr;
    d_addr = a;
    d_wdata = wd;
    pushData(wr, a, wd);
    waitValid(1'b1, "data");
    d_rd = 1'b0;
    d_wr = 1'b0;
  endtask

  task automatic doBoth(input logic [15:0] fa, input bit wr, input logic [15:0] da,
                        input logic [15:0] wd);
    if_req = 1'b1;
    if_addr = fa;
    d_rd = ~wr;
    d_wr = wr;
    d_addr = da;
    d_wdata = wd;
    pushData(wr, da, wd);
    accQ.push_back('{addr: fa, wr: 1'b0, wdata: 16'h0});
    ifQ.push_back(refRead(fa));
    waitValid(1'b1, "both_data");
    check("turnaround_idle", mem_req, 0);
    d_rd = 1'b0;
    d_wr = 1'b0;
    tick();
    check("turnaround_fetch_req", mem_req, 1);
    if (if_valid) check("fetch_before_grant", 1, 0);
    else waitValid(1'b0, "both_fetch");
    if_req = 1'b0;
  endtask

  task automatic doFlush(input logic [15:0] a, input logic [15:0] b);
    if_req = 1'b1;
    if_addr = a;
    accQ.push_back('{addr: a, wr: 1'b0, wdata: 16'h0});
    waitMemReq("flush");
    flush = 1'b1;
    if_addr = b;
    accQ.push_back('{addr: b, wr: 1'b0, wdata: 16'h0});
    ifQ.push_back(refRead(b));
    tick();
    flush = 1'b0;
    waitValid(1'b0, "flush_refetch");
    if_req = 1'b0;
  endtask

  function automatic logic [15:0] rndFetch();
    return 16'h0040 + 16'(2 * $urandom_range(0, 15));
  endfunction

  function automatic logic [15:0] rndData();
    return 16'h2000 + 16'($urandom_range(0, 7));
  endfunction

  initial begin : driver
    int cnt;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Directed cases
    doFetch(16'h0040);
    doBoth(16'h0010, 1'b0, 16'h2000, 16'h0);
    doData(1'b1, 16'h3000, 16'h1234);
    doData(1'b0, 16'h3000, 16'h0);
    doFlush(16'h0050, 16'h0080);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: doFetch(rndFetch());
        1: doData(1'b0, rndData(), 16'h0);
        2: doData(1'b1, rndData(), 16'($urandom));
        3: doBoth(rndFetch(), 1'($urandom_range(0, 1)), rndData(), 16'($urandom));
        default: doFlush(rndFetch(), rndFetch());
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    // Timeout: memory never answers
    hang = 1'b1;
    d_rd = 1'b1;
    d_addr = 16'h2004;
    accQ.push_back('{addr: 16'h2004, wr: 1'b0, wdata: 16'h0});
    waitMemReq("timeout");
    cnt = 1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (!mem_req) break;
      cnt++;
    end
    d_rd = 1'b0;
    hang = 1'b0;
    check("timeout_cycles", cnt, TO);
    check("timeout_err", err, 1);
    $display("timeout cycles=%0d err=%0b", cnt, err);
    tick();
    doFetch(rndFetch());
    doData(1'b0, rndData(), 16'h0);
    check("err_sticky", err, 1);

    // Reset in the middle of a data access
    hang = 1'b1;
    d_rd = 1'b1;
    d_addr = 16'h2006;
    accQ.push_back('{addr: 16'h2006, wr: 1'b0, wdata: 16'h0});
    waitMemReq("reset_mid");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_mem_req", mem_req, 0);
    check("reset_err", err, 0);
    d_rd = 1'b0;
    hang = 1'b0;
    lastRd = 16'h0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("reset_no_d_valid", d_valid, 0);
    end
    doData(1'b0, rndData(), 16'h0);
    doFetch(rndFetch());
    repeat (4) tick();

    check("accQ_drained", accQ.size(), 0);
    check("ifQ_drained", ifQ.size(), 0);
    check("dQ_drained", dQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
